// File: rtl/dm_arbiter_pkg.sv
// rtl/dm_arbiter_pkg.sv - shared FSM encodings and port ids for the data memory arbiter
package dm_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LSU   = 1'b1;

endpackage

// File: rtl/dm_arbiter_if.sv
// rtl/dm_arbiter_if.sv - requester and memory-side signal bundle for dm_arbiter
interface dm_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] rdata0;
  logic              ack0;
  logic              err0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic [DATA_W-1:0] rdata1;
  logic              ack1;
  logic              err1;

  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, addr0, req1, we1, addr1, wdata1, mem_rdata,
    output rdata0, ack0, err0, rdata1, ack1, err1,
    output mem_write, mem_address, mem_wdata
  );

  modport master (
    output req0, addr0, req1, we1, addr1, wdata1, mem_rdata,
    input  rdata0, ack0, err0, rdata1, ack1, err1,
    input  mem_write, mem_address, mem_wdata
  );

endinterface

// File: rtl/dm_arbiter_rr_arb2.sv
// rtl/dm_arbiter_rr_arb2.sv - combinational two-way round-robin pick
module rr_arb2
  import dm_arbiter_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_grant,
  output logic o_valid,
  output logic o_grant
);

  // On a tie the port that did not win last time goes first.
  always_comb begin
    o_valid = i_req0 | i_req1;
    o_grant = PORT_FETCH;
    if (i_req0 && i_req1) begin
      o_grant = ~i_last_grant;
    end else if (i_req1) begin
      o_grant = PORT_LSU;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - round-robin sharing of the single-port data memory between fetch and LSU
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 4096
) (
  input  logic         clock,
  input  logic         reset_n,
  dm_arbiter_if.slave  bus
);

  state_t            r_state;
  state_t            w_next_state;
  logic              r_last_grant;
  logic              r_grant;
  logic              r_we;
  logic              r_err;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_address;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic              r_ack0;
  logic              r_ack1;
  logic              r_err0;
  logic              r_err1;

  logic              w_valid;
  logic              w_grant;
  logic              w_we;
  logic              w_err;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  rr_arb2 u_rr_arb2 (
    .i_req0       (bus.req0),
    .i_req1       (bus.req1),
    .i_last_grant (r_last_grant),
    .o_valid      (w_valid),
    .o_grant      (w_grant)
  );

  // Fetch is read-only, so its write enable and write data are forced off.
  assign w_addr  = (w_grant == PORT_LSU) ? bus.addr1 : bus.addr0;
  assign w_we    = (w_grant == PORT_LSU) & bus.we1;
  assign w_wdata = (w_grant == PORT_LSU) ? bus.wdata1 : '0;
  assign w_err   = (w_addr >= ADDR_W'(MEM_BYTES));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = IDLE;
    case (r_state)
      IDLE:    w_next_state = w_valid ? ACCESS : IDLE;
      ACCESS:  w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_last_grant  <= PORT_LSU;
      r_grant       <= PORT_FETCH;
      r_we          <= 1'b0;
      r_err         <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
      r_rdata0      <= '0;
      r_rdata1      <= '0;
      r_ack0        <= 1'b0;
      r_ack1        <= 1'b0;
      r_err0        <= 1'b0;
      r_err1        <= 1'b0;
    end else begin
      r_mem_write <= 1'b0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_err0      <= 1'b0;
      r_err1      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_grant       <= w_grant;
            r_we          <= w_we;
            r_err         <= w_err;
            r_last_grant  <= w_grant;
            r_mem_address <= w_addr;
            r_mem_wdata   <= w_wdata;
            r_mem_write   <= w_we & ~w_err;
          end
        end
        // Read data is captured at the end of ACCESS so ack and rdata rise together in DONE.
        ACCESS: begin
          if (r_grant == PORT_FETCH) begin
            r_ack0 <= 1'b1;
            r_err0 <= r_err;
            if (r_err) begin
              r_rdata0 <= '0;
            end else if (!r_we) begin
              r_rdata0 <= bus.mem_rdata;
            end
          end else begin
            r_ack1 <= 1'b1;
            r_err1 <= r_err;
            if (r_err) begin
              r_rdata1 <= '0;
            end else if (!r_we) begin
              r_rdata1 <= bus.mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_write   = r_mem_write;
  assign bus.mem_address = r_mem_address;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.rdata0      = r_rdata0;
  assign bus.rdata1      = r_rdata1;
  assign bus.ack0        = r_ack0;
  assign bus.ack1        = r_ack1;
  assign bus.err0        = r_err0;
  assign bus.err1        = r_err1;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - self-checking bench for dm_arbiter
module tb_dm_arbiter;
  import dm_arbiter_pkg::*;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  dm_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dm_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(4096)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [31:0] mem [0:1023];
  logic        bd_we = 1'b0;
  logic [9:0]  bd_idx = '0;
  logic [31:0] bd_data = '0;

  always @(posedge clock) begin
    if (bus.mem_write === 1'b1) mem[bus.mem_address[11:2]] <= bus.mem_wdata;
    else if (bd_we) mem[bd_idx] <= bd_data;
  end
  assign bus.mem_rdata = mem[bus.mem_address[11:2]];

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_mw;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] data);
    bd_idx = idx;
    bd_data = data;
    bd_we = 1'b1;
    @(negedge clock);
    bd_we = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.req0 = 1'b0;
    bus.addr0 = '0;
    bus.req1 = 1'b0;
    bus.we1 = 1'b0;
    bus.addr1 = '0;
    bus.wdata1 = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_write"}, 32'(bus.mem_write), 0);
    check({tag, "_ack0"}, 32'(bus.ack0), 0);
    check({tag, "_ack1"}, 32'(bus.ack1), 0);
    check({tag, "_err0"}, 32'(bus.err0), 0);
    check({tag, "_err1"}, 32'(bus.err1), 0);
    check({tag, "_mem_address"}, bus.mem_address, 0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    check({tag, "_rdata0"}, bus.rdata0, 0);
    check({tag, "_rdata1"}, bus.rdata1, 0);
    check({tag, "_state"}, 32'(dut.r_state), 32'(IDLE));
  endtask

  // Called at a negedge with the arbiter idle; returns at a negedge with it idle again.
  task automatic run_txn(input vec_t v, input string name);
    int ack_k = -1;
    int mw = 0;
    if (v.port) begin
      bus.req1 = 1'b1;
      bus.we1 = v.we;
      bus.addr1 = v.addr;
      bus.wdata1 = v.wdata;
    end else begin
      bus.req0 = 1'b1;
      bus.addr0 = v.addr;
      bus.we1 = 1'b1;
      bus.wdata1 = 32'hFFFF_FFFF;
    end
    for (int k = 1; k <= 10 && ack_k < 0; k++) begin
      @(negedge clock);
      if (bus.mem_write === 1'b1) mw++;
      if ((v.port ? bus.ack1 : bus.ack0) === 1'b1) begin
        ack_k = k;
        check({name, "_other_ack"}, 32'(v.port ? bus.ack0 : bus.ack1), 0);
        check({name, "_err"}, 32'(v.port ? bus.err1 : bus.err0), 32'(v.exp_err));
        if (v.chk_rd) check({name, "_rdata"}, v.port ? bus.rdata1 : bus.rdata0, v.exp_rd);
      end
    end
    check({name, "_ack_latency"}, 32'(ack_k), 2);
    idle_inputs();
    @(negedge clock);
    if (bus.mem_write === 1'b1) mw++;
    check({name, "_ack_one_cycle"}, 32'({bus.ack0, bus.ack1}), 0);
    check({name, "_mem_write_cycles"}, 32'(mw), 32'(v.exp_mw));
  endtask

  initial begin
    int a0_cnt;
    int both_cnt;

    vecs[0] = '{1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0, 1};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 0};
    vecs[2] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,         1'b1, 32'h1234_5678, 1'b0, 0};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_1000, 32'hA5A5_A5A5, 1'b1, 32'h0,         1'b1, 0};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'hCAFE_F00D, 1'b0, 0};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,         1'b1, 32'h0BAD_C0DE, 1'b0, 0};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,         1'b1, 32'h0,         1'b1, 0};
    vecs[7] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0,         1'b1, 0};
    vecs[8] = '{1'b1, 1'b1, 32'h0000_0FFC, 32'h1111_2222, 1'b0, 32'h0,         1'b0, 1};
    vecs[9] = '{1'b1, 1'b0, 32'h0000_0FFE, 32'h0,         1'b1, 32'h1111_2222, 1'b0, 0};

    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    preload(10'd16, 32'h1234_5678);
    preload(10'd0, 32'hCAFE_F00D);
    preload(10'd1023, 32'h0BAD_C0DE);
    preload(10'd8, 32'h0000_0000);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Tie held continuously from just after reset: 0,1,0,1 with acks every 3 cycles.
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    bus.req0 = 1'b1;
    bus.addr0 = 32'h40;
    bus.req1 = 1'b1;
    bus.we1 = 1'b0;
    bus.addr1 = 32'h10;
    both_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      if (bus.ack0 === 1'b1 && bus.ack1 === 1'b1) both_cnt++;
      check($sformatf("tie_ack0_k%0d", k), 32'(bus.ack0), 32'((k % 6) == 2));
      check($sformatf("tie_ack1_k%0d", k), 32'(bus.ack1), 32'((k % 6) == 5));
      if (bus.ack0 === 1'b1) check($sformatf("tie_rdata0_k%0d", k), bus.rdata0, 32'h1234_5678);
      if (bus.ack1 === 1'b1) check($sformatf("tie_rdata1_k%0d", k), bus.rdata1, 32'hDEAD_BEEF);
      if (k == 11) idle_inputs();
    end
    check("tie_ack_overlap", 32'(both_cnt), 0);
    @(negedge clock);

    // Fetch request dropped right after grant still completes exactly once.
    bus.req0 = 1'b1;
    bus.addr0 = 32'h40;
    @(negedge clock);
    bus.req0 = 1'b0;
    check("drop_mem_address", bus.mem_address, 32'h40);
    @(negedge clock);
    check("drop_ack0", 32'(bus.ack0), 1);
    check("drop_rdata0", bus.rdata0, 32'h1234_5678);
    a0_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (bus.ack0 !== 1'b0) a0_cnt++;
    end
    check("drop_no_regrant", 32'(a0_cnt), 0);

    // Reset during the ACCESS cycle of a store aborts it.
    bus.req1 = 1'b1;
    bus.we1 = 1'b1;
    bus.addr1 = 32'h20;
    bus.wdata1 = 32'h7777_7777;
    @(negedge clock);
    check("rstmid_access_write", 32'(bus.mem_write), 1);
    reset_n = 1'b0;
    idle_inputs();
    @(negedge clock);
    check_reset_outputs("rstmid");
    reset_n = 1'b1;
    bus.req0 = 1'b1;
    bus.addr0 = 32'h40;
    bus.req1 = 1'b1;
    bus.addr1 = 32'h10;
    @(negedge clock);
    check("rstmid_no_write_after", 32'(bus.mem_write), 0);
    @(negedge clock);
    check("rstmid_tie_ack0", 32'(bus.ack0), 1);
    check("rstmid_tie_ack1", 32'(bus.ack1), 0);
    check("rstmid_tie_rdata0", bus.rdata0, 32'h1234_5678);
    idle_inputs();
    repeat (3) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares the single-port 4 KB data memory between two requesters: port 0 (instruction fetch, read-only) and port 1 (load/store unit, read/write).
- Sits between the multi-cycle CPU's fetch/memory stages and the data memory.
- Arbitrates round-robin, sequences each access through a 3-state FSM, registers the memory-side signals, and returns read data with a one-cycle ack pulse.

Parameters:
- ADDR_W, 32, byte-address width of all address ports.
- DATA_W, 32, word width.
- MEM_BYTES, 4096, memory size in bytes; addresses >= MEM_BYTES are out of range.

Ports:
- clock  input  1  system clock, all logic on posedge
- reset_n  input  1  synchronous reset, active-low
- req0  input  1  fetch request
- addr0  input  ADDR_W  fetch byte address
- rdata0  output  DATA_W  fetch read data, valid while ack0=1
- ack0  output  1  fetch completion pulse
- err0  output  1  fetch out-of-range flag, valid while ack0=1
- req1  input  1  load/store request
- we1  input  1  1=store, 0=load
- addr1  input  ADDR_W  load/store byte address
- wdata1  input  DATA_W  store data
- rdata1  output  DATA_W  load data, valid while ack1=1
- ack1  output  1  load/store completion pulse
- err1  output  1  load/store out-of-range flag, valid while ack1=1
- mem_write  output  1  to memory write enable
- mem_address  output  ADDR_W  to memory address
- mem_wdata  output  DATA_W  to memory write data
- mem_rdata  input  DATA_W  from memory combinational read data

Behaviour:
- Reset (reset_n=0 at posedge) drives the following values:
  - state=IDLE, last_grant=1.
  - mem_write, ack0, ack1, err0, err1 = 0.
  - mem_address, mem_wdata, rdata0, rdata1 = 0.
- Reset asserted mid-transaction aborts it. No write occurs after the reset edge. The requester must re-issue.
- FSM states are IDLE, ACCESS and DONE.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that port.
  - Both reqs: grant the port not equal to last_grant (round-robin). After reset, port 0 wins the first tie.
  - On grant:
    - Register grant id, we (forced to 0 for port 0), address and wdata into mem_address/mem_wdata.
    - Set last_grant=grant id.
    - Go to ACCESS.
- ACCESS (exactly one cycle):
  - In range, store: mem_write=1 for this cycle only.
  - In range, load: capture mem_rdata into the granted port's rdata register at this edge.
  - Out of range (address >= MEM_BYTES): mem_write stays 0, rdata captures 0, err latched.
  - Go to DONE.
- DONE (exactly one cycle):
  - ack of the granted port = 1, with rdata and err valid.
  - The other port's ack = 0.
  - Go to IDLE.
- Latency: a req seen in IDLE at edge N produces ack high during cycle N+2. Peak throughput is one transaction per 3 cycles.
- Handshake:
  - Requester holds req, we1, addr, wdata stable until it sees ack.
  - req still high in the IDLE cycle after DONE is a new transaction. This is how back-to-back accesses are issued.
  - Fields are latched at grant, so dropping req early still completes the transaction and pulses ack.
- ack0 and ack1 are never high in the same cycle. Each ack is high for exactly one cycle per transaction.
- Starvation bound: a waiting requester is granted within 6 cycles of req assertion.
- rdata0/rdata1 hold their last value outside ack. Values outside ack are not guaranteed to the consumer.
- mem_write is never high outside ACCESS.
- The memory uses address[11:2]. The arbiter passes byte addresses through unmodified. Misalignment is not flagged.

Decomposition:
- Shared package/header holds:
  - FSM state encodings: IDLE=2'd0, ACCESS=2'd1, DONE=2'd2.
  - Port id constants: PORT_FETCH=0, PORT_LSU=1.
- One sub-module: rr_arb2 (combinational two-way round-robin pick from req0, req1, last_grant). The FSM and datapath registers stay in dm_arbiter.

Test Plan:
- Single store then load:
  - Stimulus: req1 we1=1 addr1=0x10 wdata1=0xDEADBEEF, then a load from 0x10.
  - Required: mem_write high exactly one cycle; ack1 at N+2; load returns rdata1=0xDEADBEEF with err1=0.
- Fetch read:
  - Stimulus: memory word at 0x40 preloaded with 0x12345678; req0 addr0=0x40.
  - Required: ack0 at N+2, rdata0=0x12345678, mem_write never high.
- Simultaneous requests held continuously:
  - Stimulus: req0 and req1 asserted together from just after reset.
  - Required: grants alternate 0,1,0,1; acks every 3 cycles, never overlapping.
- Out of range:
  - Stimulus: req1 we1=1 addr1=0x1000.
  - Required: mem_write stays 0, ack1=1 with err1=1; memory word 0 unchanged.
- Reset mid-transaction:
  - Stimulus: reset_n=0 during the ACCESS cycle of a store.
  - Required: no ack; all outputs 0 next cycle; state IDLE. The next tie after reset grants port 0.
- Early req drop:
  - Stimulus: req0 dropped the cycle after grant.
  - Required: ack0 still pulses at N+2; no further grant to port 0.
